pc_counter_stage: RTL and testbench

- Registered program-counter stage that drives the WIDTH-bit ripple incrementor and captures its sum and carry-out each time the downstream consumer accepts the current value.
- Sits between control (start/stop/load) and the fetch consumer, which reads the count through a valid/ready handshake.
- Adds load (jump), run/idle/halt control, wrap or halt on overflow, and a sticky overflow flag.

---
 rtl/pc_counter_stage_pkg.sv | 12 +
 rtl/pc_counter_stage_incr.sv | 24 ++
 rtl/pc_counter_stage.sv | 101 ++++++++++
 tb/tb_pc_counter_stage.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pc_counter_stage_pkg.sv
// Shared constants and types for the program-counter stage.
package pc_counter_stage_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_t;

endpackage : pc_counter_stage_pkg

// File: rtl/pc_counter_stage_incr.sv
// Structural half-adder ripple incrementor (sum = a + 1, carry-in tied high).
module pc_incr
  import pc_counter_stage_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  input  logic [WIDTH-1:0] a
);

  logic [WIDTH:0] c;

  assign c[0] = 1'b1;

  // One half adder per bit; carry ripples from the lsb upward.
  for (genvar i = 0; i < WIDTH; i++) begin : g_ha
    assign sum[i]  = a[i] ^ c[i];
    assign c[i+1]  = a[i] & c[i];
  end

  assign carry = c[WIDTH];

endmodule : pc_incr

// File: rtl/pc_counter_stage.sv
// Registered program counter with load/run/halt control, valid/ready output
// handshake, wrap-or-halt on overflow and a sticky overflow flag.
module pc_counter_stage
  import pc_counter_stage_pkg::*;
#(
  parameter int unsigned       WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
  parameter bit                WRAP        = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clear_ovf,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] q,
  output logic             ovf,
  output logic             tc,
  output logic             halted
);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] q_next;
  logic             ovf_next;
  logic             out_valid_next;
  logic             halted_next;

  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             accept;

  pc_incr #(.WIDTH(WIDTH)) u_incr (
    .sum   (sum),
    .carry (carry),
    .a     (q)
  );

  // out_valid is a registered copy of (state == RUN), so accept never
  // depends combinationally on out_ready through out_valid.
  assign accept = out_valid & out_ready;
  assign tc     = &q;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      q         <= RESET_VALUE;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      halted    <= 1'b0;
    end else begin
      state     <= state_next;
      q         <= q_next;
      ovf       <= ovf_next;
      out_valid <= out_valid_next;
      halted    <= halted_next;
    end
  end

  // Next-state logic: load beats stop beats start/accept.
  always_comb begin
    state_next = state;
    if (load) begin
      state_next = ST_RUN;
    end else if (stop) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (start) state_next = ST_RUN;
        ST_RUN:  if (accept && carry && !WRAP) state_next = ST_HALT;
        ST_HALT: state_next = ST_HALT;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Datapath and output next values; a stop-cycle transfer does not advance q.
  always_comb begin
    q_next         = q;
    ovf_next       = ovf;
    out_valid_next = (state_next == ST_RUN);
    halted_next    = (state_next == ST_HALT);

    if (load) begin
      q_next = load_value;
    end else if (!stop && accept) begin
      q_next = (carry && !WRAP) ? q : sum;
    end

    if (!load && !stop && accept && carry) begin
      ovf_next = 1'b1;
    end else if (clear_ovf) begin
      ovf_next = 1'b0;
    end
  end

endmodule : pc_counter_stage

// File: tb/tb_pc_counter_stage.sv
// Bench for pc_counter_stage: a wrapping and a halting instance share stimulus
// and are checked every cycle against a behavioural model.
module tb_pc_counter_stage;

  localparam int unsigned MAXV = 32'hFFFF;

  logic        clk = 1'b0;
  logic        reset, start, stop, load, clear_ovf, out_ready;
  logic [15:0] load_value;

  logic        w_valid, w_ovf, w_tc, w_halted;
  logic [15:0] w_q;
  logic        h_valid, h_ovf, h_tc, h_halted;
  logic [15:0] h_q;

  int checks = 0;
  int errors = 0;

  // Model state: index 0 = wrapping instance, 1 = halting instance.
  int unsigned m_q    [2];
  bit          m_run  [2];
  bit          m_halt [2];
  bit          m_ovf  [2];

  always #5 clk = ~clk;

  pc_counter_stage #(.WIDTH(16), .RESET_VALUE(16'h0000), .WRAP(1'b1)) dut_w (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .load(load),
    .load_value(load_value), .clear_ovf(clear_ovf), .out_ready(out_ready),
    .out_valid(w_valid), .q(w_q), .ovf(w_ovf), .tc(w_tc), .halted(w_halted)
  );

  pc_counter_stage #(.WIDTH(16), .RESET_VALUE(16'h0000), .WRAP(1'b0)) dut_h (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .load(load),
    .load_value(load_value), .clear_ovf(clear_ovf), .out_ready(out_ready),
    .out_valid(h_valid), .q(h_q), .ovf(h_ovf), .tc(h_tc), .halted(h_halted)
  );

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one rising edge using the inputs the DUTs sampled.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit acc, at_max;
      acc    = m_run[k] && out_ready;
      at_max = (m_q[k] == MAXV);
      if (reset) begin
        m_q[k] = 0; m_run[k] = 0; m_halt[k] = 0; m_ovf[k] = 0;
      end else begin
        if (acc && !load && !stop && at_max) m_ovf[k] = 1;
        else if (clear_ovf)                  m_ovf[k] = 0;
        if (load) begin
          m_q[k] = 32'(load_value); m_run[k] = 1; m_halt[k] = 0;
        end else if (stop) begin
          m_run[k] = 0; m_halt[k] = 0;
        end else if (!m_run[k] && !m_halt[k]) begin
          if (start) m_run[k] = 1;
        end else if (m_run[k] && acc) begin
          if (!at_max)     m_q[k] = m_q[k] + 1;
          else if (k == 0) m_q[k] = 0;
          else begin m_run[k] = 0; m_halt[k] = 1; end
        end
      end
    end
  endtask

  task automatic compare_all();
    check("w_q",      32'(w_q),      m_q[0]);
    check("w_valid",  32'(w_valid),  32'(m_run[0]));
    check("w_halted", 32'(w_halted), 32'(m_halt[0]));
    check("w_ovf",    32'(w_ovf),    32'(m_ovf[0]));
    check("w_tc",     32'(w_tc),     32'(m_q[0] == MAXV));
    check("h_q",      32'(h_q),      m_q[1]);
    check("h_valid",  32'(h_valid),  32'(m_run[1]));
    check("h_halted", 32'(h_halted), 32'(m_halt[1]));
    check("h_ovf",    32'(h_ovf),    32'(m_ovf[1]));
    check("h_tc",     32'(h_tc),     32'(m_q[1] == MAXV));
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      #1;
      compare_all();
    end
  endtask

  initial begin
    reset = 1; start = 0; stop = 0; load = 0; load_value = '0;
    clear_ovf = 0; out_ready = 0;
    for (int k = 0; k < 2; k++) begin
      m_q[k] = 32'hDEAD; m_run[k] = 0; m_halt[k] = 0; m_ovf[k] = 0;
    end
    step(2);
    check("lit_reset_q", 32'(w_q), 0);
    check("lit_reset_valid", 32'(w_valid), 0);

    // Count from reset: 0,1,2,3 on consecutive valid cycles.
    reset = 0; start = 1; out_ready = 1;
    step(1);
    check("lit_first_q", 32'(w_q), 0);
    check("lit_first_valid", 32'(w_valid), 1);
    start = 0;
    step(3);
    check("lit_count3", 32'(w_q), 3);
    check("lit_count3_ovf", 32'(w_ovf), 0);

    // Backpressure at 5.
    step(2);
    out_ready = 0;
    step(3);
    check("lit_stall_q", 32'(w_q), 5);
    check("lit_stall_valid", 32'(w_valid), 1);
    out_ready = 1;
    step(1);
    check("lit_resume_q", 32'(w_q), 6);

    // Overflow: wrap instance wraps, halting instance halts.
    load = 1; load_value = 16'hFFFE;
    step(1);
    load = 0;
    step(1);
    check("lit_tc", 32'(w_tc), 1);
    step(1);
    check("lit_wrap_q", 32'(w_q), 0);
    check("lit_wrap_ovf", 32'(w_ovf), 1);
    check("lit_halt_q", 32'(h_q), 32'hFFFF);
    check("lit_halt_flag", 32'(h_halted), 1);
    check("lit_halt_valid", 32'(h_valid), 0);
    start = 1;
    step(1);
    check("lit_halt_start_ignored", 32'(h_halted), 1);
    start = 0; clear_ovf = 1;
    step(1);
    check("lit_clear_ovf", 32'(w_ovf), 0);
    clear_ovf = 0; load = 1; load_value = 16'h0010;
    step(1);
    check("lit_halt_reload_q", 32'(h_q), 32'h10);
    check("lit_halt_reload_valid", 32'(h_valid), 1);

    // load and stop together with a transfer: load wins.
    load = 1; stop = 1; load_value = 16'h1234;
    step(1);
    check("lit_loadstop_q", 32'(w_q), 32'h1234);
    check("lit_loadstop_valid", 32'(w_valid), 1);
    load = 0;
    step(1);
    check("lit_stop_q", 32'(w_q), 32'h1234);
    check("lit_stop_valid", 32'(w_valid), 0);
    stop = 0;

    // Reach q=0x42 with ovf set, then reset mid-run.
    load = 1; load_value = 16'hFFFF;
    step(1);
    load = 0;
    step(1);
    load = 1; load_value = 16'h0042;
    step(1);
    check("lit_pre_reset_ovf", 32'(w_ovf), 1);
    load = 0; out_ready = 0; reset = 1;
    step(1);
    check("lit_mid_reset_q", 32'(w_q), 0);
    check("lit_mid_reset_ovf", 32'(w_ovf), 0);
    reset = 0;

    // clear_ovf coinciding with a wrapping accept: set wins.
    load = 1; load_value = 16'hFFFF;
    step(1);
    load = 0; clear_ovf = 1; out_ready = 1;
    step(1);
    check("lit_set_wins_ovf", 32'(w_ovf), 1);
    check("lit_set_wins_q", 32'(w_q), 0);
    clear_ovf = 0;

    // Randomised phase.
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 199) == 0);
      load      = ($urandom_range(0, 19) == 0);
      load_value = ($urandom_range(0, 1) == 0) ? 16'($urandom)
                                               : 16'(16'hFFF0 + $urandom_range(0, 15));
      stop      = ($urandom_range(0, 24) == 0);
      start     = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      clear_ovf = ($urandom_range(0, 9) == 0);
      step(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pc_counter_stage
